gbfb_bank_ctrl: RTL and testbench
=================================

# gbfb_bank_ctrl

Triple-buffer bank controller between the Game Boy input decoder and the 3-bank framebuffer RAM. The decoder writes one 160x144 2-bit frame (23040 pixels) into a private bank while the VGA scanout reads another. Only complete frames are published to the reader, so the VGA output never shows a torn or partial GB frame. The block translates 15-bit pixel indices into 17-bit RAM addresses and reports dropped and repeated frames.

## Interface
Parameters:
- FRAME_PIXELS, 23040: pixels per GB frame (160*144); bank size and completeness threshold.

Ports:
- clk  in  1  system clock (40 MHz PLL domain, shared with decoder and scanout)
- rst_n  in  1  asynchronous active-low reset
- wr_frame_start  in  1  one-cycle pulse: filtered GB vsync rising edge, new input frame begins
- wr_en  in  1  one-cycle pixel write strobe from decoder
- wr_pixel  in  15  pixel index of write, 0..FRAME_PIXELS-1
- wr_data  in  2  pixel value
- rd_frame_start  in  1  one-cycle pulse: VGA counters wrap to frame start (h=0, v=0)
- rd_pixel  in  15  scanout pixel index (0 when not visible)
- mem_wren  out  1  RAM write enable
- mem_wraddr  out  17  RAM write address
- mem_wdata  out  2  RAM write data
- mem_rdaddr  out  17  RAM read address
- wr_bank  out  2  bank currently owned by writer
- rd_bank  out  2  bank currently shown by reader
- frames_dropped  out  8  saturating count of frames discarded
- frames_repeated  out  8  saturating count of reader frames with no new frame available

## Operation
- Three banks 0,1,2; base(b) = b*FRAME_PIXELS (0, 23040, 46080). Registers wr_bank, rd_bank, spare_bank always a permutation of {0,1,2}; fresh flag marks spare_bank as holding an unread complete frame.
- Writer FSM: W_IDLE, W_ACTIVE. Reset -> W_IDLE. W_IDLE: wr_en ignored; wr_frame_start -> W_ACTIVE, write count cleared. W_ACTIVE: accepted writes increment write count (15 bits, saturate at 32767).
- Write accepted iff state is W_ACTIVE (after applying same-cycle wr_frame_start) and wr_pixel < FRAME_PIXELS. Rejected writes: no mem_wren, not counted.
- wr_frame_start in W_ACTIVE closes the current frame:
  - count == FRAME_PIXELS exactly: publish. If fresh already set, frames_dropped += 1 (old fresh frame overwritten). Swap wr_bank <-> spare_bank; fresh <= 1.
  - otherwise: frame incomplete, frames_dropped += 1, banks unchanged, fresh unchanged.
  - Count cleared; state stays W_ACTIVE.
- rd_frame_start: if fresh, swap rd_bank <-> spare_bank, fresh <= 0; else frames_repeated += 1, banks unchanged.
- Same-cycle wr_frame_start and rd_frame_start: writer close evaluated first, reader swap uses resulting state, so a frame completed that cycle is shown immediately.
- wr_en in same cycle as wr_frame_start: write belongs to the new frame (new wr_bank, counted as first write of new frame).
- mem_rdaddr = base(rd_bank) + rd_pixel; rd_pixel >= FRAME_PIXELS maps to base(rd_bank).
- Counters saturate at 255, never wrap.

## Timing
- Reset values: wr_bank=0, rd_bank=1, spare_bank=2, fresh=0, state W_IDLE, count 0, mem_wren=0, mem_wraddr=0, mem_wdata=0, frames_dropped=0, frames_repeated=0.
- Write path registered: mem_wren/mem_wraddr/mem_wdata valid exactly 1 cycle after wr_en; address uses wr_bank after any same-cycle swap.
- Read path combinational from rd_pixel and registered rd_bank; zero added latency, so scanout pipeline depth is unchanged.
- Bank swaps take effect on the clock edge of the triggering pulse; wr_bank/rd_bank outputs are those registers.
- Reset mid-frame: all state returns to reset values immediately (async); an in-flight registered write is cancelled (mem_wren=0).

## Test plan
- Reset, then rd_frame_start x3 with no writes -> rd_bank stays 1, frames_repeated=3, mem_wren never asserted.
- wr_frame_start, 23040 writes pixel 0..23039, wr_frame_start, rd_frame_start -> wr_bank=2, rd_bank=0; read of rd_pixel=5 gives mem_rdaddr=5; write pixel 7 in new frame gives mem_wraddr=46087 one cycle later.
- Frame of 23039 writes then wr_frame_start -> frames_dropped=1, banks unchanged, next rd_frame_start increments frames_repeated.
- Two complete frames without rd_frame_start -> frames_dropped=1, fresh=1; next rd_frame_start shows the second frame's bank.
- Complete frame with wr_frame_start, rd_frame_start, wr_en all in same cycle -> new frame displayed that cycle (rd_bank=0), write lands in bank 2 and counts toward new frame; wr_pixel=23040 -> no mem_wren.
- 300 rd_frame_start without frames -> frames_repeated=255; assert rst_n low mid-frame -> all outputs to reset values within same cycle.

Source files
------------

// File: rtl/gbfb_bank_ctrl.sv
// Triple-buffer bank controller between the GB pixel decoder and the 3-bank framebuffer RAM.
// Only complete frames are handed to the VGA reader; torn or partial frames are dropped and counted.
module gbfb_bank_ctrl #(
    parameter int unsigned FRAME_PIXELS = 23040
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_frame_start,
    input  logic        wr_en,
    input  logic [14:0] wr_pixel,
    input  logic [1:0]  wr_data,
    input  logic        rd_frame_start,
    input  logic [14:0] rd_pixel,
    output logic        mem_wren,
    output logic [16:0] mem_wraddr,
    output logic [1:0]  mem_wdata,
    output logic [16:0] mem_rdaddr,
    output logic [1:0]  wr_bank,
    output logic [1:0]  rd_bank,
    output logic [7:0]  frames_dropped,
    output logic [7:0]  frames_repeated
);

    typedef enum logic [0:0] {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } wstate_t;

    localparam logic [16:0] FP17  = 17'(FRAME_PIXELS);
    localparam logic [14:0] FP15  = 15'(FRAME_PIXELS);
    localparam logic [14:0] CNT_MAX = 15'h7FFF;

    function automatic logic [16:0] f_base(input logic [1:0] bank);
        logic [16:0] base;
        case (bank)
            2'd0:    base = 17'd0;
            2'd1:    base = FP17;
            2'd2:    base = 17'(2 * FRAME_PIXELS);
            default: base = 17'd0;
        endcase
        return base;
    endfunction

    function automatic logic [7:0] f_sat_inc8(input logic [7:0] v);
        logic [7:0] n;
        if (v == 8'hFF) begin
            n = v;
        end else begin
            n = v + 8'd1;
        end
        return n;
    endfunction

    wstate_t     r_state;
    logic [14:0] r_count;
    logic [1:0]  r_wr_bank;
    logic [1:0]  r_rd_bank;
    logic [1:0]  r_spare_bank;
    logic        r_fresh;
    logic        r_mem_wren;
    logic [16:0] r_mem_wraddr;
    logic [1:0]  r_mem_wdata;
    logic [7:0]  r_frames_dropped;
    logic [7:0]  r_frames_repeated;

    logic        w_close;
    logic        w_complete;
    logic        w_drop;
    logic        w_repeat;
    logic        w_active;
    logic        w_accept;
    logic [1:0]  w_wr_bank;
    logic [1:0]  w_spare_mid;
    logic        w_fresh_mid;
    logic [1:0]  w_rd_bank;
    logic [1:0]  w_spare_bank;
    logic        w_fresh;
    logic [14:0] w_count;
    logic [16:0] w_rd_off;

    // Next bank/fresh state: writer close resolves first, reader swap sees its result.
    always_comb begin
        w_close     = wr_frame_start && (r_state == W_ACTIVE);
        w_complete  = w_close && (r_count == FP15);
        w_wr_bank   = r_wr_bank;
        w_spare_mid = r_spare_bank;
        w_fresh_mid = r_fresh;
        w_drop      = 1'b0;
        if (w_complete) begin
            w_wr_bank   = r_spare_bank;
            w_spare_mid = r_wr_bank;
            w_fresh_mid = 1'b1;
            w_drop      = r_fresh;
        end else if (w_close) begin
            w_drop = 1'b1;
        end else begin
            w_drop = 1'b0;
        end

        w_rd_bank    = r_rd_bank;
        w_spare_bank = w_spare_mid;
        w_fresh      = w_fresh_mid;
        w_repeat     = 1'b0;
        if (rd_frame_start) begin
            if (w_fresh_mid) begin
                w_rd_bank    = w_spare_mid;
                w_spare_bank = r_rd_bank;
                w_fresh      = 1'b0;
            end else begin
                w_repeat = 1'b1;
            end
        end else begin
            w_repeat = 1'b0;
        end
    end

    // Write acceptance and per-frame write count; a same-cycle frame start opens the frame first.
    always_comb begin
        w_active = wr_frame_start || (r_state == W_ACTIVE);
        w_accept = wr_en && w_active && ({2'b00, wr_pixel} < FP17);
        w_count  = r_count;
        if (wr_frame_start) begin
            w_count = {14'd0, w_accept};
        end else if (w_accept && (r_count != CNT_MAX)) begin
            w_count = r_count + 15'd1;
        end else begin
            w_count = r_count;
        end
    end

    // Scanout address: out-of-range pixels fold onto the bank base.
    always_comb begin
        if ({2'b00, rd_pixel} < FP17) begin
            w_rd_off = {2'b00, rd_pixel};
        end else begin
            w_rd_off = 17'd0;
        end
    end

    // Writer FSM, bank registers, registered RAM write port and saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= W_IDLE;
            r_count           <= 15'd0;
            r_wr_bank         <= 2'd0;
            r_rd_bank         <= 2'd1;
            r_spare_bank      <= 2'd2;
            r_fresh           <= 1'b0;
            r_mem_wren        <= 1'b0;
            r_mem_wraddr      <= 17'd0;
            r_mem_wdata       <= 2'd0;
            r_frames_dropped  <= 8'd0;
            r_frames_repeated <= 8'd0;
        end else begin
            case (r_state)
                W_IDLE: begin
                    if (wr_frame_start) begin
                        r_state <= W_ACTIVE;
                    end else begin
                        r_state <= W_IDLE;
                    end
                end
                W_ACTIVE: r_state <= W_ACTIVE;
                default:  r_state <= W_IDLE;
            endcase
            r_count      <= w_count;
            r_wr_bank    <= w_wr_bank;
            r_rd_bank    <= w_rd_bank;
            r_spare_bank <= w_spare_bank;
            r_fresh      <= w_fresh;
            r_mem_wren   <= w_accept;
            if (w_accept) begin
                r_mem_wraddr <= f_base(w_wr_bank) + {2'b00, wr_pixel};
                r_mem_wdata  <= wr_data;
            end else begin
                r_mem_wraddr <= r_mem_wraddr;
                r_mem_wdata  <= r_mem_wdata;
            end
            if (w_drop) begin
                r_frames_dropped <= f_sat_inc8(r_frames_dropped);
            end else begin
                r_frames_dropped <= r_frames_dropped;
            end
            if (w_repeat) begin
                r_frames_repeated <= f_sat_inc8(r_frames_repeated);
            end else begin
                r_frames_repeated <= r_frames_repeated;
            end
        end
    end

    assign mem_wren        = r_mem_wren;
    assign mem_wraddr      = r_mem_wraddr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_rdaddr      = f_base(r_rd_bank) + w_rd_off;
    assign wr_bank         = r_wr_bank;
    assign rd_bank         = r_rd_bank;
    assign frames_dropped  = r_frames_dropped;
    assign frames_repeated = r_frames_repeated;

endmodule

// File: tb/tb_gbfb_bank_ctrl.sv
// Directed bench for gbfb_bank_ctrl: write-port expectations go through a scoreboard queue,
// bank/counter/read-address expectations are hand-derived constants.
module tb_gbfb_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_frame_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [14:0] wr_pixel = 15'd0;
    logic [1:0]  wr_data = 2'd0;
    logic        rd_frame_start = 1'b0;
    logic [14:0] rd_pixel = 15'd0;
    logic        mem_wren;
    logic [16:0] mem_wraddr;
    logic [1:0]  mem_wdata;
    logic [16:0] mem_rdaddr;
    logic [1:0]  wr_bank;
    logic [1:0]  rd_bank;
    logic [7:0]  frames_dropped;
    logic [7:0]  frames_repeated;

    typedef struct {
        logic        en;
        logic [16:0] addr;
        logic [1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    gbfb_bank_ctrl #(.FRAME_PIXELS(23040)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_frame_start  (wr_frame_start),
        .wr_en           (wr_en),
        .wr_pixel        (wr_pixel),
        .wr_data         (wr_data),
        .rd_frame_start  (rd_frame_start),
        .rd_pixel        (rd_pixel),
        .mem_wren        (mem_wren),
        .mem_wraddr      (mem_wraddr),
        .mem_wdata       (mem_wdata),
        .mem_rdaddr      (mem_rdaddr),
        .wr_bank         (wr_bank),
        .rd_bank         (rd_bank),
        .frames_dropped  (frames_dropped),
        .frames_repeated (frames_repeated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the expected registered write is queued before the edge and checked after it.
    task automatic step(input logic wfs, input logic en, input int pix, input logic rfs,
                        input logic exp_en, input int exp_addr);
        exp_t e;
        logic [1:0] d;
        d = 2'(pix + (pix >> 5));
        wr_frame_start = wfs;
        wr_en          = en;
        wr_pixel       = 15'(pix);
        wr_data        = d;
        rd_frame_start = rfs;
        e.en   = exp_en;
        e.addr = 17'(exp_addr);
        e.data = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wr_frame_start = 1'b0;
        wr_en          = 1'b0;
        rd_frame_start = 1'b0;
        e = sb.pop_front();
        chk("mem_wren", 32'(mem_wren), 32'(e.en));
        if (e.en) begin
            chk("mem_wraddr", 32'(mem_wraddr), 32'(e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
        end
    endtask

    task automatic chk_state(input string tag, input int wb, input int rb, input int dr, input int rp);
        chk({tag, ".wr_bank"}, 32'(wr_bank), 32'(wb));
        chk({tag, ".rd_bank"}, 32'(rd_bank), 32'(rb));
        chk({tag, ".dropped"}, 32'(frames_dropped), 32'(dr));
        chk({tag, ".repeated"}, 32'(frames_repeated), 32'(rp));
    endtask

    task automatic chk_rd(input string tag, input int pix, input int exp_addr);
        rd_pixel = 15'(pix);
        #1;
        chk(tag, 32'(mem_rdaddr), 32'(exp_addr));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 1, 0, 0);
        chk("reset.wren", 32'(mem_wren), 32'd0);
        chk("reset.wraddr", 32'(mem_wraddr), 32'd0);
        chk("reset.wdata", 32'(mem_wdata), 32'd0);
        chk_rd("reset.rdaddr5", 5, 23045);
        chk_rd("reset.rdaddr_oob", 23040, 23040);
        rst_n = 1'b1;

        // Writes ignored while idle; reader repeats with no frame available
        step(1'b0, 1'b1, 3, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        chk_state("repeat3", 0, 1, 0, 3);

        // Frame 1 into bank 0; first write shares the cycle with the frame start
        step(1'b1, 1'b1, 0, 1'b0, 1'b1, 0);
        for (int p = 1; p < 23040; p++) step(1'b0, 1'b1, p, 1'b0, 1'b1, p);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        chk_state("publish1", 2, 1, 0, 3);

        // Frame 2 into bank 2, closed together with a reader start and a new-frame write
        for (int p = 0; p < 23040; p++) step(1'b0, 1'b1, p, 1'b0, 1'b1, 46080 + p);
        step(1'b1, 1'b1, 7, 1'b1, 1'b1, 7);
        chk_state("samecycle", 0, 2, 1, 3);
        chk_rd("samecycle.rdaddr5", 5, 46085);
        step(1'b0, 1'b1, 23040, 1'b0, 1'b0, 0);

        // Incomplete frame: 1 + 23038 accepted writes, the rejected one must not count
        for (int p = 0; p < 23038; p++) step(1'b0, 1'b1, p, 1'b0, 1'b1, p);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        chk_state("incomplete", 0, 2, 2, 3);
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        chk_state("repeat_after_drop", 0, 2, 2, 4);

        // Repeat counter saturates
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        chk_state("saturate", 0, 2, 2, 255);
        chk_rd("saturate.rdaddr_oob", 30000, 46080);

        // Asynchronous reset with a registered write in flight
        step(1'b0, 1'b1, 9, 1'b0, 1'b1, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("midreset", 0, 1, 0, 0);
        chk("midreset.wren", 32'(mem_wren), 32'd0);
        chk("midreset.wraddr", 32'(mem_wraddr), 32'd0);
        chk("midreset.wdata", 32'(mem_wdata), 32'd0);
        chk_rd("midreset.rdaddr5", 5, 23045);
        #2;
        rst_n = 1'b1;

        // Back to normal after reset: idle write rejected, then a new frame writes bank 0
        step(1'b0, 1'b1, 4, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 7, 1'b0, 1'b1, 7);
        chk_state("postreset", 0, 1, 0, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
